pc_hazard_ctrl: RTL and testbench
=================================

Name: pc_hazard_ctrl

Overview:
Next-PC and hazard controller for the 5-stage RISC-V pipeline.
- Computes the PC register's next value: sequential, EX-resolved redirect, or hold.
- Drives the PC hold input and the IF/ID and ID/EX hold and flush controls.
- Covers load-use stalls, instruction-memory wait states and branch/jump redirects, including redirects that arrive while instruction memory is busy.
- Keeps saturating stall and redirect counters for performance analysis.

Parameters:
DATA_WIDTH, 32, PC and target width
REG_ADDR_WIDTH, 5, register index width
RESET_PC, 0, next_pc value while rst is asserted
CNT_WIDTH, 32, width of each performance counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
pc_cur  input  DATA_WIDTH  current PC register output
imem_ready  input  1  instruction fetch at pc_cur completes this cycle
ex_mem_read  input  1  instruction in EX is a load
ex_rd  input  REG_ADDR_WIDTH  destination register of EX instruction
id_rs1  input  REG_ADDR_WIDTH  rs1 of ID instruction
id_rs2  input  REG_ADDR_WIDTH  rs2 of ID instruction
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
ex_redirect  input  1  taken branch or jump resolved in EX
ex_target  input  DATA_WIDTH  redirect target
next_pc  output  DATA_WIDTH  PC register data input
pc_hold  output  1  PC register hold (PC keeps its value)
if_id_hold  output  1  IF/ID register holds
if_id_flush  output  1  IF/ID loads a bubble
id_ex_flush  output  1  ID/EX loads a bubble
redirect_pending  output  1  high in state REDIR_PEND
stall_cycles  output  CNT_WIDTH  count of cycles with pc_hold=1
redirect_count  output  CNT_WIDTH  count of accepted redirects

Behaviour:
Clock and reset:
- One clock, clk. Reset is synchronous and active-high on rst.
- While rst=1, outputs are forced: next_pc=RESET_PC, pc_hold=0, if_id_hold=0, if_id_flush=1, id_ex_flush=1.
- At the reset clock edge: state=RUN, pend_target=0, both counters=0, redirect_pending=0.

Structure:
- Control outputs are combinational from state and inputs. State, pend_target and counters are registered.
- Load-use term: lu = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Defaults: next_pc=pc_cur+4 (modulo 2^DATA_WIDTH, wraps), all controls 0.
- Whenever pc_hold=1, next_pc=pc_cur.

State RUN, evaluated in strict priority order:
1. ex_redirect & imem_ready: next_pc=ex_target, if_id_flush=1, id_ex_flush=1. The redirect is accepted. Stay in RUN.
2. ex_redirect & !imem_ready: pc_hold=1, if_id_flush=1, id_ex_flush=1. Latch pend_target=ex_target and go to REDIR_PEND. The redirect counts as accepted this cycle.
3. lu: pc_hold=1, if_id_hold=1, id_ex_flush=1. This is a single bubble whatever imem_ready is; lu clears the next cycle because EX then holds a bubble.
4. !imem_ready: pc_hold=1, if_id_flush=1.
5. Otherwise: sequential fetch, next_pc=pc_cur+4.

State REDIR_PEND:
- if_id_flush=1 and id_ex_flush=1 every cycle.
- ex_redirect and lu are ignored. ex_redirect is illegal here because EX holds a bubble.
- While !imem_ready: pc_hold=1.
- When imem_ready: next_pc=pend_target, pc_hold=0, go to RUN.

Counters:
- stall_cycles increments on every non-reset cycle with pc_hold=1.
- redirect_count increments on each accepted redirect (RUN items 1 and 2).
- Both saturate at 2^CNT_WIDTH-1 and never wrap.

Reset mid-operation: reset in REDIR_PEND discards pend_target. There is no redirect after reset.

Test Plan:
1. Load-use: pc_cur=0x10, ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1, imem_ready=1 -> one cycle of pc_hold=1, if_id_hold=1, id_ex_flush=1, next_pc=0x10. Next cycle with lu cleared -> next_pc=0x14, stall_cycles=1. The same stimulus with ex_rd=0, or with id_use_rs1=0 -> no stall.
2. Redirect with imem_ready=1: pc_cur=0x40, ex_redirect=1, ex_target=0x100 -> next_pc=0x100, if_id_flush=1, id_ex_flush=1, redirect_count=1, state stays RUN.
3. Redirect with imem_ready=0 for 3 cycles: ex_target=0x200 -> redirect_pending=1, pc_hold=1 and both flushes for 3 cycles. On the 4th cycle (imem_ready=1) -> next_pc=0x200, back to RUN, stall_cycles=3, redirect_count=1.
4. Simultaneous redirect and lu, imem_ready=1 -> redirect wins: next_pc=ex_target, pc_hold=0, if_id_hold=0.
5. imem wait: imem_ready=0 for 2 cycles, no hazards -> pc_hold=1, if_id_flush=1, next_pc=pc_cur. Then ready -> next_pc=pc_cur+4. Wrap check: pc_cur=0xFFFFFFFC -> next_pc=0x0.
6. rst=1 during REDIR_PEND -> outputs forced as above; afterwards state=RUN, counters=0, no pending redirect applied. Saturation check with CNT_WIDTH=4: 20 stall cycles -> stall_cycles=15.

Source files
------------

// File: rtl/pc_hazard_ctrl.sv
// Next-PC selection and pipeline hazard control for a 5-stage RISC-V core.
// Handles load-use stalls, fetch wait states and EX redirects, with performance counters.
module pc_hazard_ctrl #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    REG_ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_PC       = '0,
  parameter int                    CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     pc_cur,
  input  logic                      imem_ready,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic                      ex_redirect,
  input  logic [DATA_WIDTH-1:0]     ex_target,
  output logic [DATA_WIDTH-1:0]     next_pc,
  output logic                      pc_hold,
  output logic                      if_id_hold,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      redirect_pending,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      redirect_count
);

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    REDIR_PEND = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [DATA_WIDTH-1:0]   r_pend_target;
  logic [DATA_WIDTH-1:0]   w_pend_target_next;
  logic [CNT_WIDTH-1:0]    r_stall_cycles;
  logic [CNT_WIDTH-1:0]    r_redirect_count;
  logic                    w_lu;
  logic                    w_accept;

  assign w_lu = ex_mem_read && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    next_pc            = pc_cur + DATA_WIDTH'(4);
    pc_hold            = 1'b0;
    if_id_hold         = 1'b0;
    if_id_flush        = 1'b0;
    id_ex_flush        = 1'b0;
    w_accept           = 1'b0;
    w_state_next       = r_state;
    w_pend_target_next = r_pend_target;
    if (rst) begin
      next_pc      = RESET_PC;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      w_state_next = RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (ex_redirect && imem_ready) begin
            next_pc     = ex_target;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_accept    = 1'b1;
          end else if (ex_redirect) begin
            // Fetch still busy: park the target until the current fetch drains.
            pc_hold            = 1'b1;
            if_id_flush        = 1'b1;
            id_ex_flush        = 1'b1;
            w_accept           = 1'b1;
            w_pend_target_next = ex_target;
            w_state_next       = REDIR_PEND;
          end else if (w_lu) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            pc_hold     = 1'b1;
            if_id_flush = 1'b1;
          end
        end
        REDIR_PEND: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (imem_ready) begin
            next_pc      = r_pend_target;
            w_state_next = RUN;
          end else begin
            pc_hold = 1'b1;
          end
        end
        default: w_state_next = RUN;
      endcase
    end
    if (pc_hold) next_pc = pc_cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= RUN;
      r_pend_target    <= '0;
      r_stall_cycles   <= '0;
      r_redirect_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pend_target <= w_pend_target_next;
      if (pc_hold && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      if (w_accept && (r_redirect_count != '1)) r_redirect_count <= r_redirect_count + CNT_WIDTH'(1);
    end
  end

  assign redirect_pending = (r_state == REDIR_PEND);
  assign stall_cycles     = r_stall_cycles;
  assign redirect_count   = r_redirect_count;

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Bench for pc_hazard_ctrl: directed scenarios plus a randomized run against a
// cycle-level behavioural model; a second instance with 4-bit counters checks saturation.
module tb_pc_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic        imem_ready;
  logic        ex_mem_read;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_redirect;
  logic [31:0] ex_target;

  logic [31:0] next_pc;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_flush, redirect_pending;
  logic [31:0] stall_cycles, redirect_count;

  logic [31:0] s_next_pc;
  logic        s_pc_hold, s_if_id_hold, s_if_id_flush, s_id_ex_flush, s_redirect_pending;
  logic [3:0]  s_stall, s_redir;

  integer checks = 0;
  integer errors = 0;

  always #5 clk = ~clk;

  pc_hazard_ctrl dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .imem_ready(imem_ready),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .next_pc(next_pc), .pc_hold(pc_hold),
    .if_id_hold(if_id_hold), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .redirect_pending(redirect_pending), .stall_cycles(stall_cycles),
    .redirect_count(redirect_count)
  );

  pc_hazard_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .imem_ready(imem_ready),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .next_pc(s_next_pc), .pc_hold(s_pc_hold),
    .if_id_hold(s_if_id_hold), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .redirect_pending(s_redirect_pending), .stall_cycles(s_stall),
    .redirect_count(s_redir)
  );

  // Reference model: a pending-redirect flag plus counters kept as plain integers.
  typedef struct packed {
    logic [31:0] npc;
    logic        hold;
    logic        idh;
    logic        idf;
    logic        exf;
  } exp_t;

  bit          m_pend = 1'b0;
  logic [31:0] m_tgt  = '0;
  longint      m_stall = 0, m_redir = 0, m_stall4 = 0, m_redir4 = 0;

  function automatic exp_t model_out();
    exp_t e;
    bit   lu;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    e = '0;
    e.npc = pc_cur + 32'd4;
    if (rst) begin
      e.npc = 32'h0; e.idf = 1; e.exf = 1;
    end else if (m_pend) begin
      e.idf = 1; e.exf = 1;
      if (imem_ready) e.npc = m_tgt; else e.hold = 1;
    end else if (ex_redirect) begin
      e.idf = 1; e.exf = 1;
      if (imem_ready) e.npc = ex_target; else e.hold = 1;
    end else if (lu) begin
      e.hold = 1; e.idh = 1; e.exf = 1;
    end else if (!imem_ready) begin
      e.hold = 1; e.idf = 1;
    end
    if (e.hold) e.npc = pc_cur;
    return e;
  endfunction

  function automatic longint sat(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic tick();
    exp_t e;
    bit   acc;
    e = model_out();
    acc = !rst && !m_pend && ex_redirect;
    @(posedge clk);
    if (rst) begin
      m_pend = 0; m_tgt = '0; m_stall = 0; m_redir = 0; m_stall4 = 0; m_redir4 = 0;
    end else begin
      if (e.hold) begin
        m_stall  = sat(m_stall + 1, 64'hFFFF_FFFF);
        m_stall4 = sat(m_stall4 + 1, 15);
      end
      if (acc) begin
        m_redir  = sat(m_redir + 1, 64'hFFFF_FFFF);
        m_redir4 = sat(m_redir4 + 1, 15);
      end
      if (m_pend) m_pend = !imem_ready;
      else if (ex_redirect && !imem_ready) begin
        m_pend = 1; m_tgt = ex_target;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; imem_ready = 1; ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_redirect = 0; ex_target = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; pc_cur = 32'h1234;
    tick(); tick();
    #1;
    checks++;
    if (next_pc !== 32'h0 || {pc_hold, if_id_hold, if_id_flush, id_ex_flush} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_outputs: got npc=%h ctl=%b, want npc=0 ctl=0011", next_pc,
               {pc_hold, if_id_hold, if_id_flush, id_ex_flush});
    end
    checks++;
    if (stall_cycles !== 0 || redirect_count !== 0 || redirect_pending !== 0) begin
      errors++;
      $display("FAIL reset_state: got stall=%0d redir=%0d pend=%b, want 0 0 0",
               stall_cycles, redirect_count, redirect_pending);
    end
    $display("test_reset done");
    rst = 0;
    tick();
  endtask

  task automatic test_load_use();
    idle(); pc_cur = 32'h10; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; #1;
    checks++;
    if ({pc_hold, if_id_hold, if_id_flush, id_ex_flush} !== 4'b1101 || next_pc !== 32'h10) begin
      errors++;
      $display("FAIL lu_stall: got npc=%h ctl=%b, want npc=10 ctl=1101", next_pc,
               {pc_hold, if_id_hold, if_id_flush, id_ex_flush});
    end
    tick(); ex_mem_read = 0; #1;
    checks++;
    if (next_pc !== 32'h14 || pc_hold !== 1'b0 || stall_cycles !== 32'd1) begin
      errors++;
      $display("FAIL lu_release: got npc=%h hold=%b stall=%0d, want 14 0 1",
               next_pc, pc_hold, stall_cycles);
    end
    tick(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; #1;
    checks++;
    if (pc_hold !== 1'b0 || next_pc !== 32'h14) begin
      errors++;
      $display("FAIL lu_rd_zero: got hold=%b npc=%h, want 0 14", pc_hold, next_pc);
    end
    tick(); ex_rd = 5; id_rs1 = 5; id_use_rs1 = 0; #1;
    checks++;
    if (pc_hold !== 1'b0 || id_ex_flush !== 1'b0) begin
      errors++;
      $display("FAIL lu_no_use: got hold=%b exf=%b, want 0 0", pc_hold, id_ex_flush);
    end
    $display("test_load_use done");
    tick();
  endtask

  task automatic test_redirect_ready();
    idle(); pc_cur = 32'h40; ex_redirect = 1; ex_target = 32'h100; #1;
    checks++;
    if (next_pc !== 32'h100 || {pc_hold, if_id_flush, id_ex_flush} !== 3'b011) begin
      errors++;
      $display("FAIL redir_ready: got npc=%h ctl=%b, want 100 011", next_pc,
               {pc_hold, if_id_flush, id_ex_flush});
    end
    tick(); ex_redirect = 0; #1;
    checks++;
    if (redirect_count !== 32'd1 || redirect_pending !== 1'b0) begin
      errors++;
      $display("FAIL redir_ready_cnt: got cnt=%0d pend=%b, want 1 0", redirect_count, redirect_pending);
    end
    $display("test_redirect_ready done");
    tick();
  endtask

  task automatic test_redirect_wait();
    longint st0, rd0;
    st0 = m_stall; rd0 = m_redir;
    idle(); pc_cur = 32'h44; ex_redirect = 1; ex_target = 32'h200; imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({pc_hold, if_id_flush, id_ex_flush} !== 3'b111 || next_pc !== 32'h44 ||
          redirect_pending !== (i > 0)) begin
        errors++;
        $display("FAIL redir_wait[%0d]: got ctl=%b npc=%h pend=%b, want 111 44 %b", i,
                 {pc_hold, if_id_flush, id_ex_flush}, next_pc, redirect_pending, i > 0);
      end
      tick();
      ex_target = 32'h999;
    end
    imem_ready = 1; #1;
    checks++;
    if (next_pc !== 32'h200 || pc_hold !== 1'b0 || redirect_pending !== 1'b1) begin
      errors++;
      $display("FAIL redir_wait_apply: got npc=%h hold=%b pend=%b, want 200 0 1",
               next_pc, pc_hold, redirect_pending);
    end
    tick(); ex_redirect = 0; #1;
    checks++;
    if (redirect_pending !== 1'b0 || stall_cycles !== 32'(st0 + 3) ||
        redirect_count !== 32'(rd0 + 1)) begin
      errors++;
      $display("FAIL redir_wait_cnt: got pend=%b stall=%0d redir=%0d, want 0 %0d %0d",
               redirect_pending, stall_cycles, redirect_count, st0 + 3, rd0 + 1);
    end
    $display("test_redirect_wait done");
    tick();
  endtask

  task automatic test_priority();
    idle(); pc_cur = 32'h60; ex_redirect = 1; ex_target = 32'h300;
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; #1;
    checks++;
    if (next_pc !== 32'h300 || pc_hold !== 1'b0 || if_id_hold !== 1'b0) begin
      errors++;
      $display("FAIL redir_over_lu: got npc=%h hold=%b idh=%b, want 300 0 0",
               next_pc, pc_hold, if_id_hold);
    end
    $display("test_priority done");
    tick();
  endtask

  task automatic test_imem_wait();
    idle(); pc_cur = 32'h80; imem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({pc_hold, if_id_hold, if_id_flush, id_ex_flush} !== 4'b1010 || next_pc !== 32'h80) begin
        errors++;
        $display("FAIL imem_wait[%0d]: got ctl=%b npc=%h, want 1010 80", i,
                 {pc_hold, if_id_hold, if_id_flush, id_ex_flush}, next_pc);
      end
      tick();
    end
    imem_ready = 1; #1;
    checks++;
    if (next_pc !== 32'h84 || pc_hold !== 1'b0) begin
      errors++;
      $display("FAIL imem_ready: got npc=%h hold=%b, want 84 0", next_pc, pc_hold);
    end
    tick(); pc_cur = 32'hFFFF_FFFC; #1;
    checks++;
    if (next_pc !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap: got npc=%h, want 0", next_pc);
    end
    $display("test_imem_wait done");
    tick();
  endtask

  task automatic test_reset_mid();
    idle(); pc_cur = 32'h70; ex_redirect = 1; ex_target = 32'h400; imem_ready = 0;
    tick(); ex_redirect = 0; #1;
    checks++;
    if (redirect_pending !== 1'b1) begin
      errors++;
      $display("FAIL mid_pend: got pend=%b, want 1", redirect_pending);
    end
    rst = 1; #1;
    checks++;
    if (next_pc !== 32'h0 || {pc_hold, if_id_hold, if_id_flush, id_ex_flush} !== 4'b0011) begin
      errors++;
      $display("FAIL mid_reset_out: got npc=%h ctl=%b, want 0 0011", next_pc,
               {pc_hold, if_id_hold, if_id_flush, id_ex_flush});
    end
    tick(); rst = 0; imem_ready = 1; pc_cur = 32'h80; #1;
    checks++;
    if (next_pc !== 32'h84 || redirect_pending !== 1'b0 || stall_cycles !== 0 ||
        redirect_count !== 0) begin
      errors++;
      $display("FAIL mid_reset_after: got npc=%h pend=%b stall=%0d redir=%0d, want 84 0 0 0",
               next_pc, redirect_pending, stall_cycles, redirect_count);
    end
    $display("test_reset_mid done");
    tick();
  endtask

  task automatic test_saturation();
    idle(); pc_cur = 32'h90; imem_ready = 0;
    for (int i = 0; i < 20; i++) tick();
    imem_ready = 1; #1;
    checks++;
    if (s_stall !== 4'd15 || stall_cycles !== 32'd20) begin
      errors++;
      $display("FAIL stall_saturate: got narrow=%0d wide=%0d, want 15 20", s_stall, stall_cycles);
    end
    $display("test_saturation done");
    tick();
  endtask

  task automatic test_random();
    exp_t e;
    for (int n = 0; n < 1500; n++) begin
      rst         = ($urandom_range(63) == 0);
      imem_ready  = ($urandom_range(9) < 7);
      ex_mem_read = 1'($urandom_range(1));
      ex_rd       = 5'($urandom_range(3));
      id_rs1      = 5'($urandom_range(3));
      id_rs2      = 5'($urandom_range(3));
      id_use_rs1  = 1'($urandom_range(1));
      id_use_rs2  = 1'($urandom_range(1));
      ex_redirect = ($urandom_range(5) == 0);
      ex_target   = $urandom & 32'hFFFF_FFFC;
      pc_cur      = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      #1;
      e = model_out();
      checks++;
      if ({next_pc, pc_hold, if_id_hold, if_id_flush, id_ex_flush} !== e) begin
        errors++;
        $display("FAIL rand_out[%0d]: got npc=%h ctl=%b, want npc=%h ctl=%b", n, next_pc,
                 {pc_hold, if_id_hold, if_id_flush, id_ex_flush}, e.npc,
                 {e.hold, e.idh, e.idf, e.exf});
      end
      checks++;
      if (redirect_pending !== m_pend || stall_cycles !== 32'(m_stall) ||
          redirect_count !== 32'(m_redir)) begin
        errors++;
        $display("FAIL rand_state[%0d]: got pend=%b stall=%0d redir=%0d, want %b %0d %0d", n,
                 redirect_pending, stall_cycles, redirect_count, m_pend, m_stall, m_redir);
      end
      checks++;
      if (s_stall !== 4'(m_stall4) || s_redir !== 4'(m_redir4)) begin
        errors++;
        $display("FAIL rand_narrow[%0d]: got stall=%0d redir=%0d, want %0d %0d", n,
                 s_stall, s_redir, m_stall4, m_redir4);
      end
      tick();
    end
    $display("test_random done");
  endtask

  initial begin
    idle(); rst = 1; pc_cur = 0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_redirect_ready();
    test_redirect_wait();
    test_priority();
    test_imem_wait();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
